mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arbiter_if.sv | 29 ++
 rtl/mem_arbiter_store.sv | 18 +
 rtl/mem_arbiter.sv | 89 ++++++++
 tb/tb_mem_arbiter.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: access size codes, FSM states and alignment helper for the memory arbiter
package mem_arbiter_pkg;
  localparam int MEM_TYPE_LEN = 3;
  localparam logic [MEM_TYPE_LEN-1:0] MEM_B  = 3'd0;
  localparam logic [MEM_TYPE_LEN-1:0] MEM_H  = 3'd1;
  localparam logic [MEM_TYPE_LEN-1:0] MEM_W  = 3'd2;
  localparam logic [MEM_TYPE_LEN-1:0] MEM_BU = 3'd4;
  localparam logic [MEM_TYPE_LEN-1:0] MEM_HU = 3'd5;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  function automatic logic misaligned(input logic [MEM_TYPE_LEN-1:0] t, input logic [1:0] a);
    return ((t == MEM_H || t == MEM_HU) && a[0]) || (t == MEM_W && a != 2'b00);
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store and memory bus signals of the arbiter
interface mem_arbiter_if #(parameter int XLEN = 32);
  logic                                     if_req;
  logic [XLEN-1:0]                          if_addr;
  logic                                     if_ready;
  logic [XLEN-1:0]                          if_rdata;
  logic                                     ls_req;
  logic                                     ls_we;
  logic [XLEN-1:0]                          ls_addr;
  logic [mem_arbiter_pkg::MEM_TYPE_LEN-1:0] ls_type;
  logic [XLEN-1:0]                          ls_wdata;
  logic                                     ls_ready;
  logic [XLEN-1:0]                          ls_rdata;
  logic                                     ls_err;
  logic                                     mem_en;
  logic                                     mem_we;
  logic [3:0]                               mem_wmask;
  logic [XLEN-1:0]                          mem_addr;
  logic [XLEN-1:0]                          mem_wdata;
  logic [XLEN-1:0]                          mem_rdata;
  modport master (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_type, ls_wdata, mem_rdata,
    output if_ready, if_rdata, ls_ready, ls_rdata, ls_err, mem_en, mem_we, mem_wmask, mem_addr, mem_wdata
  );
  modport slave (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_type, ls_wdata, mem_rdata,
    input  if_ready, if_rdata, ls_ready, ls_rdata, ls_err, mem_en, mem_we, mem_wmask, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_store.sv
// mem_store: byte-lane write mask and lane-replicated store data
module mem_store
  import mem_arbiter_pkg::*;
(
  input  logic [1:0]              addr,
  input  logic [31:0]             data,
  input  logic [MEM_TYPE_LEN-1:0] store_type,
  output logic [3:0]              wmask,
  output logic [31:0]             wdata
);
  logic word, half;
  always_comb begin
    word  = store_type == MEM_W;
    half  = store_type == MEM_H || store_type == MEM_HU;
    wmask = word ? 4'b1111 : (half ? 4'b0011 : 4'b0001) << addr;
    wdata = word ? data : half ? {2{data[15:0]}} : {4{data[7:0]}};
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between fetch and load/store ports onto one fixed-latency memory
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEM_LATENCY = 1
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.master bus
);
  state_t      state;
  logic [2:0]  cnt;
  logic        last_ls, if_elig, ls_elig, grant_ls, mis;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  mem_store u_store (
    .addr       (bus.ls_addr[1:0]),
    .data       (bus.ls_wdata),
    .store_type (bus.ls_type),
    .wmask      (st_mask),
    .wdata      (st_data)
  );
  always_comb begin
    if_elig  = bus.if_req && !bus.if_ready;
    ls_elig  = bus.ls_req && !bus.ls_ready && !bus.ls_err;
    grant_ls = ls_elig && (!if_elig || !last_ls);
    mis      = misaligned(bus.ls_type, bus.ls_addr[1:0]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      last_ls       <= 1'b0;
      bus.if_ready  <= 1'b0;
      bus.ls_ready  <= 1'b0;
      bus.ls_err    <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_wmask <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.ls_rdata  <= '0;
    end else begin
      bus.if_ready  <= 1'b0;
      bus.ls_ready  <= 1'b0;
      bus.ls_err    <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_wmask <= '0;
      case (state)
        IDLE: begin
          if (grant_ls) begin
            last_ls    <= 1'b1;
            bus.ls_err <= mis;
            if (!mis) begin
              bus.mem_en    <= 1'b1;
              bus.mem_we    <= bus.ls_we;
              bus.mem_wmask <= bus.ls_we ? st_mask : 4'b0000;
              bus.mem_addr  <= bus.ls_addr & ~XLEN'(3);
              bus.mem_wdata <= bus.ls_we ? st_data : bus.mem_wdata;
              cnt           <= 3'(MEM_LATENCY);
              state         <= WAIT;
            end
          end else if (if_elig) begin
            last_ls      <= 1'b0;
            bus.mem_en   <= 1'b1;
            bus.mem_addr <= bus.if_addr & ~XLEN'(3);
            cnt          <= 3'(MEM_LATENCY);
            state        <= WAIT;
          end
        end
        WAIT: begin
          cnt   <= cnt - 3'd1;
          state <= cnt == 3'd1 ? DONE : WAIT;
        end
        DONE: begin
          state        <= IDLE;
          bus.ls_ready <= last_ls;
          bus.if_ready <= !last_ls;
          bus.ls_rdata <= last_ls ? bus.mem_rdata : bus.ls_rdata;
          bus.if_rdata <= last_ls ? bus.if_rdata : bus.mem_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector and sequence checks of the memory arbiter
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  typ;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] eaddr;
    logic [3:0]  mask;
    logic [31:0] ewdata;
    logic [31:0] rdata;
  } vec_t;
  logic clk = 1'b0;
  logic reset1, reset2;
  always #5 clk = ~clk;
  mem_arbiter_if #(.XLEN(32)) b1();
  mem_arbiter_if #(.XLEN(32)) b2();
  mem_arbiter #(.XLEN(32), .MEM_LATENCY(1)) dut1 (.clk(clk), .reset(reset1), .bus(b1));
  mem_arbiter #(.XLEN(32), .MEM_LATENCY(3)) dut2 (.clk(clk), .reset(reset2), .bus(b2));
  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  logic        v1;
  logic [31:0] d1;
  logic [2:0]  v2;
  logic [31:0] d2a, d2b, d2c;
  always @(posedge clk) begin
    v1  <= b1.mem_en;
    d1  <= f(b1.mem_addr);
    v2  <= {v2[1:0], b2.mem_en};
    d2a <= f(b2.mem_addr);
    d2b <= d2a;
    d2c <= d2b;
  end
  assign b1.mem_rdata = v1 ? d1 : 32'hDEADBEEF;
  assign b2.mem_rdata = v2[2] ? d2c : 32'hDEADBEEF;
  int checks = 0;
  int failures = 0;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
    end
  endtask
  vec_t        v[11];
  int          en_n, rdy_n, err_n, t_en, t_rdy, n;
  logic [31:0] g_addr, g_wd, g_rd;
  logic [3:0]  g_mask;
  logic        g_we;
  int          ord[10];
  int          cyc[10];
  initial begin
    v[0]  = '{1'b0, 32'h100, MEM_W,  32'h0,        1'b0, 32'h100, 4'b0000, 32'h0,        32'h0100FEFF};
    v[1]  = '{1'b1, 32'h103, MEM_B,  32'h000000A5, 1'b0, 32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0};
    v[2]  = '{1'b1, 32'h102, MEM_H,  32'h1234BEEF, 1'b0, 32'h100, 4'b1100, 32'hBEEFBEEF, 32'h0};
    v[3]  = '{1'b1, 32'h204, MEM_W,  32'hCAFEF00D, 1'b0, 32'h204, 4'b1111, 32'hCAFEF00D, 32'h0};
    v[4]  = '{1'b1, 32'h201, MEM_BU, 32'h0000003C, 1'b0, 32'h200, 4'b0010, 32'h3C3C3C3C, 32'h0};
    v[5]  = '{1'b1, 32'h300, MEM_HU, 32'hFFFF8001, 1'b0, 32'h300, 4'b0011, 32'h80018001, 32'h0};
    v[6]  = '{1'b0, 32'h101, MEM_H,  32'h0,        1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
    v[7]  = '{1'b0, 32'h102, MEM_W,  32'h0,        1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
    v[8]  = '{1'b1, 32'h303, MEM_HU, 32'h0,        1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
    v[9]  = '{1'b0, 32'h007, MEM_BU, 32'h0,        1'b0, 32'h004, 4'b0000, 32'h0,        32'h0004FFFB};
    v[10] = '{1'b1, 32'h004, MEM_B,  32'h12345678, 1'b0, 32'h004, 4'b0001, 32'h78787878, 32'h0};
    reset1 = 1'b1; reset2 = 1'b1;
    b1.if_req = 0; b1.if_addr = 0; b1.ls_req = 0; b1.ls_we = 0; b1.ls_addr = 0; b1.ls_type = MEM_W; b1.ls_wdata = 0;
    b2.if_req = 0; b2.if_addr = 0; b2.ls_req = 0; b2.ls_we = 0; b2.ls_addr = 0; b2.ls_type = MEM_W; b2.ls_wdata = 0;
    repeat (3) @(negedge clk);
    check("rst_if_ready", 32'(b1.if_ready), 0);
    check("rst_ls_ready", 32'(b1.ls_ready), 0);
    check("rst_ls_err", 32'(b1.ls_err), 0);
    check("rst_mem_en", 32'(b1.mem_en), 0);
    check("rst_mem_we", 32'(b1.mem_we), 0);
    check("rst_mem_wmask", 32'(b1.mem_wmask), 0);
    check("rst_mem_addr", b1.mem_addr, 0);
    check("rst_mem_wdata", b1.mem_wdata, 0);
    check("rst_if_rdata", b1.if_rdata, 0);
    check("rst_ls_rdata", b1.ls_rdata, 0);
    reset1 = 1'b0; reset2 = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      b1.ls_req = 1; b1.ls_we = v[i].we; b1.ls_addr = v[i].addr; b1.ls_type = v[i].typ; b1.ls_wdata = v[i].wdata;
      en_n = 0; rdy_n = 0; err_n = 0; t_en = -1; t_rdy = -1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (b1.mem_en) begin
          en_n++; t_en = c; g_addr = b1.mem_addr; g_mask = b1.mem_wmask; g_wd = b1.mem_wdata; g_we = b1.mem_we;
        end
        if (b1.ls_ready) begin
          rdy_n++; t_rdy = c; g_rd = b1.ls_rdata; b1.ls_req = 0;
        end
        if (b1.ls_err) begin
          err_n++; b1.ls_req = 0;
        end
      end
      b1.ls_req = 0;
      if (v[i].err) begin
        check($sformatf("v%0d_err_n", i), 32'(err_n), 1);
        check($sformatf("v%0d_en_n", i), 32'(en_n), 0);
        check($sformatf("v%0d_rdy_n", i), 32'(rdy_n), 0);
      end else begin
        check($sformatf("v%0d_err_n", i), 32'(err_n), 0);
        check($sformatf("v%0d_en_n", i), 32'(en_n), 1);
        check($sformatf("v%0d_rdy_n", i), 32'(rdy_n), 1);
        check($sformatf("v%0d_latency", i), 32'(t_rdy - t_en), 2);
        check($sformatf("v%0d_addr", i), g_addr, v[i].eaddr);
        check($sformatf("v%0d_we", i), 32'(g_we), 32'(v[i].we));
        check($sformatf("v%0d_mask", i), 32'(g_mask), 32'(v[i].mask));
        if (v[i].we) check($sformatf("v%0d_wdata", i), g_wd, v[i].ewdata);
        else check($sformatf("v%0d_rdata", i), g_rd, v[i].rdata);
      end
    end
    reset1 = 1'b1;
    repeat (2) @(negedge clk);
    reset1 = 1'b0;
    b1.if_req = 1; b1.if_addr = 32'h40; b1.ls_req = 1; b1.ls_we = 0; b1.ls_addr = 32'h80; b1.ls_type = MEM_W;
    for (int k = 0; k < 10; k++) begin ord[k] = -1; cyc[k] = 0; end
    n = 0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      @(negedge clk);
      if (b1.ls_ready) begin ord[n] = 1; cyc[n] = c; n++; end
      if (b1.if_ready && n < 10) begin ord[n] = 0; cyc[n] = c; n++; end
    end
    b1.if_req = 0; b1.ls_req = 0;
    check("rr_count", 32'(n), 10);
    for (int k = 0; k < 10; k++) check($sformatf("rr_order%0d", k), 32'(ord[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
    check("rr_span", 32'(cyc[9] - cyc[0]), 27);
    check("rr_if_rdata", b1.if_rdata, 32'h0040FFBF);
    check("rr_ls_rdata", b1.ls_rdata, 32'h0080FF7F);
    @(negedge clk);
    b2.if_req = 1; b2.if_addr = 32'h0;
    en_n = 0; rdy_n = 0; t_en = -1; t_rdy = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (b2.mem_en) begin en_n++; t_en = c; g_addr = b2.mem_addr; end
      if (b2.if_ready) begin rdy_n++; t_rdy = c; g_rd = b2.if_rdata; b2.if_req = 0; end
    end
    b2.if_req = 0;
    check("l3_en_n", 32'(en_n), 1);
    check("l3_rdy_n", 32'(rdy_n), 1);
    check("l3_latency", 32'(t_rdy - t_en), 4);
    check("l3_addr", g_addr, 32'h0);
    check("l3_rdata", g_rd, 32'h0000FFFF);
    b2.if_req = 1; b2.if_addr = 32'h8;
    en_n = 0;
    for (int c = 0; c < 5 && en_n == 0; c++) begin
      @(negedge clk);
      if (b2.mem_en) en_n++;
    end
    check("rw_en_seen", 32'(en_n), 1);
    reset2 = 1'b1;
    @(negedge clk);
    check("rw_if_ready", 32'(b2.if_ready), 0);
    check("rw_mem_en", 32'(b2.mem_en), 0);
    check("rw_mem_addr", b2.mem_addr, 0);
    check("rw_if_rdata", b2.if_rdata, 0);
    check("rw_mem_wmask", 32'(b2.mem_wmask), 0);
    reset2 = 1'b0; b2.if_req = 0;
    rdy_n = 0; en_n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (b2.if_ready) rdy_n++;
      if (b2.mem_en) en_n++;
    end
    check("rw_no_ready", 32'(rdy_n), 0);
    check("rw_no_en", 32'(en_n), 0);
    check("rw_rdata_hold", b2.if_rdata, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
